// File: rtl/demux_sequencer_pkg.sv
// Purpose: shared state encoding and dwell clamp helper for the demux sequencer.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package demux_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  // A dwell of zero still gives every enabled channel one strobe cycle.
  function automatic int unsigned dwell_clamp(input int unsigned d);
    return (d == 32'd0) ? 32'd1 : d;
  endfunction

endpackage

// File: rtl/demux_sequencer_if.sv
// Purpose: command/status bundle between a host and the demux sequencer.
// Latency: n/a (wiring only).
// Backpressure: none; start is a one-cycle pulse honoured only when idle.
interface demux_sequencer_if #(
  parameter int NO = 4,
  parameter int NS = 2,
  parameter int DW = 8
);
  logic          start;
  logic          repeat_en;
  logic          abort;
  logic [NO-1:0] ch_mask;
  logic [DW-1:0] dwell;
  logic [NS-1:0] sel;
  logic          dmx_in;
  logic          busy;
  logic          done;

  modport master (
    output start, repeat_en, abort, ch_mask, dwell,
    input  sel, dmx_in, busy, done
  );

  modport slave (
    input  start, repeat_en, abort, ch_mask, dwell,
    output sel, dmx_in, busy, done
  );
endinterface

// File: rtl/demux_sequencer_dwell_counter.sv
// Purpose: loadable down-counter timing how long a channel stays strobed.
// Latency: load/decrement take effect on the next rising edge; zero is combinational from the count.
// Backpressure: none; en is ignored once the count reaches zero.
module dwell_counter #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          en,
  input  logic [DW-1:0] load_val,
  output logic          zero
);

  logic [DW-1:0] cnt;

  // Load has priority over decrement; the count saturates at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - DW'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/demux_sequencer.sv
// Purpose: walks enabled demux channels in ascending order, strobing dmx_in for dwell cycles each.
// Latency: first enabled channel k strobes k+2 edges after start is applied; one SCAN gap between channels.
// Backpressure: start while busy is ignored; abort wins over everything and returns to idle next edge.
module demux_sequencer
  import demux_seq_pkg::*;
#(
  parameter int NO = 4,
  parameter int NS = 2,
  parameter int DW = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  demux_sequencer_if.slave   bus
);

  state_t        state, state_n;
  logic [NS-1:0] ptr, ptr_n;
  logic [NS-1:0] sel, sel_n;
  logic          dmx, dmx_n;
  logic [NO-1:0] mask_q, mask_n;
  logic [DW-1:0] dwell_q, dwell_n;
  logic          rep_q, rep_n;
  logic          cnt_load, cnt_en, cnt_zero;
  logic          last;

  localparam logic [NS-1:0] LAST_CH = NS'(NO - 1);

  assign last = (ptr == LAST_CH);

  dwell_counter #(.DW(DW)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .en       (cnt_en),
    .load_val (dwell_q - DW'(1)),
    .zero     (cnt_zero)
  );

  // State, pointer, registered outputs and the per-pass latched command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      sel     <= '0;
      dmx     <= 1'b0;
      mask_q  <= '0;
      dwell_q <= '0;
      rep_q   <= 1'b0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      sel     <= sel_n;
      dmx     <= dmx_n;
      mask_q  <= mask_n;
      dwell_q <= dwell_n;
      rep_q   <= rep_n;
    end
  end

  // Next-state logic; sel only moves on the edge that raises dmx_in or enters DONE.
  always_comb begin
    state_n  = state;
    ptr_n    = ptr;
    sel_n    = sel;
    dmx_n    = dmx;
    mask_n   = mask_q;
    dwell_n  = dwell_q;
    rep_n    = rep_q;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;

    if (bus.abort) begin
      state_n = IDLE;
      ptr_n   = '0;
      sel_n   = '0;
      dmx_n   = 1'b0;
      rep_n   = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            ptr_n = '0;
            if (bus.ch_mask != '0) begin
              mask_n  = bus.ch_mask;
              dwell_n = DW'(dwell_clamp(32'(bus.dwell)));
              rep_n   = bus.repeat_en;
              state_n = SCAN;
            end else begin
              // Empty mask: report an immediate, channel-free pass and never loop.
              rep_n   = 1'b0;
              state_n = DONE;
            end
          end
        end
        SCAN: begin
          if (mask_q[ptr]) begin
            sel_n    = ptr;
            dmx_n    = 1'b1;
            cnt_load = 1'b1;
            state_n  = HOLD;
          end else if (last) begin
            sel_n   = '0;
            state_n = DONE;
          end else begin
            ptr_n = ptr + NS'(1);
          end
        end
        HOLD: begin
          if (!cnt_zero) begin
            cnt_en = 1'b1;
          end else begin
            dmx_n = 1'b0;
            if (last) begin
              sel_n   = '0;
              state_n = DONE;
            end else begin
              ptr_n   = ptr + NS'(1);
              state_n = SCAN;
            end
          end
        end
        DONE: begin
          ptr_n   = '0;
          state_n = rep_q ? SCAN : IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign bus.sel    = sel;
  assign bus.dmx_in = dmx;
  assign bus.busy   = (state == SCAN) || (state == HOLD);
  assign bus.done   = (state == DONE);

endmodule

// File: tb/tb_demux_sequencer.sv
// Purpose: directed self-checking bench for demux_sequencer (NO=4, NS=2, DW=8).
// Latency: observes outputs 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_demux_sequencer;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  // Expected per-cycle outputs packed as {sel[1:0], dmx_in, busy, done}.
  logic [4:0] exp_q[$];

  demux_sequencer_if #(.NO(4), .NS(2), .DW(8)) bus ();

  demux_sequencer #(.NO(4), .NS(2), .DW(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] obs();
    return {bus.sel, bus.dmx_in, bus.busy, bus.done};
  endfunction

  task automatic check(input string tag, input logic [4:0] o, input logic [4:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Steps through exp_q one edge at a time; optionally pulses start (with a
  // changed mask/dwell) or abort right after the observation at a given index.
  task automatic run_trace(input string tag, input int poke_start, input int poke_abort);
    for (int i = 0; i < exp_q.size(); i++) begin
      cyc();
      check($sformatf("%s[%0d]", tag, i), obs(), exp_q[i]);
      bus.start = 1'b0;
      bus.abort = 1'b0;
      if (i == poke_start) begin
        bus.start   = 1'b1;
        bus.ch_mask = 4'b1111;
        bus.dwell   = 8'd7;
      end
      if (i == poke_abort) bus.abort = 1'b1;
    end
  endtask

  task automatic issue(input logic [3:0] m, input logic [7:0] d, input logic r);
    bus.ch_mask   = m;
    bus.dwell     = d;
    bus.repeat_en = r;
    bus.start     = 1'b1;
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.repeat_en = 1'b0;
    bus.abort     = 1'b0;
    bus.ch_mask   = '0;
    bus.dwell     = '0;

    // Reset values, then 20 quiet cycles with no start.
    cyc();
    cyc();
    check("reset", obs(), 5'b00000);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      check($sformatf("idle[%0d]", i), obs(), 5'b00000);
    end

    // mask 0101, dwell 3: sel0 x3, two gaps, sel2 x3, final scan, done, idle.
    issue(4'b0101, 8'd3, 1'b0);
    exp_q = '{5'b00010, 5'b00110, 5'b00110, 5'b00110, 5'b00010, 5'b00010,
              5'b10110, 5'b10110, 5'b10110, 5'b10010, 5'b00001, 5'b00000};
    run_trace("m0101", -1, -1);

    // Empty mask: done on the next cycle, no channel driven.
    issue(4'b0000, 8'd3, 1'b0);
    exp_q = '{5'b00001, 5'b00000};
    run_trace("m0000", -1, -1);

    // dwell 0 clamps to 1; channel 3 strobes at edge 5.
    issue(4'b1000, 8'd0, 1'b0);
    exp_q = '{5'b00010, 5'b00010, 5'b00010, 5'b00010, 5'b11110, 5'b00001, 5'b00000};
    run_trace("dw0", -1, -1);

    // Continuous passes on mask 0011 dwell 2; abort in second pass's sel1 hold.
    issue(4'b0011, 8'd2, 1'b1);
    exp_q = '{5'b00010, 5'b00110, 5'b00110, 5'b00010, 5'b01110, 5'b01110,
              5'b01010, 5'b01010, 5'b00001,
              5'b00010, 5'b00110, 5'b00110, 5'b00010, 5'b01110,
              5'b00000, 5'b00000, 5'b00000};
    run_trace("rep", -1, 13);
    bus.repeat_en = 1'b0;

    // start plus new mask/dwell mid-pass: identical pass to the first one.
    issue(4'b0101, 8'd3, 1'b0);
    exp_q = '{5'b00010, 5'b00110, 5'b00110, 5'b00110, 5'b00010, 5'b00010,
              5'b10110, 5'b10110, 5'b10110, 5'b10010, 5'b00001, 5'b00000};
    run_trace("busy_start", 3, -1);

    // start and abort together in IDLE: stays idle.
    issue(4'b0001, 8'd2, 1'b0);
    bus.abort = 1'b1;
    exp_q = '{5'b00000, 5'b00000, 5'b00000};
    run_trace("start_abort", -1, -1);

    // Async reset during the sel2 hold clears outputs before the next edge.
    issue(4'b0100, 8'd3, 1'b0);
    cyc();
    bus.start = 1'b0;
    cyc();
    cyc();
    cyc();
    check("pre_rst_hold", obs(), 5'b10110);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", obs(), 5'b00000);
    cyc();
    rst_n = 1'b1;
    cyc();
    check("post_rst", obs(), 5'b00000);

    // Fresh start after reset behaves like the first pass.
    issue(4'b0101, 8'd3, 1'b0);
    exp_q = '{5'b00010, 5'b00110, 5'b00110, 5'b00110, 5'b00010, 5'b00010,
              5'b10110, 5'b10110, 5'b10110, 5'b10010, 5'b00001, 5'b00000};
    run_trace("after_rst", -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
